int_to_float_param: RTL and testbench
=====================================

// Module: int_to_float_param
// PURPOSE
//  Multi-cycle converter from a signed or unsigned INT_W-bit integer to an IEEE-754-style float (EXP_W/MAN_W).
//  Successor to the fixed 32-bit FPU converter: parametrised width/format, per-op signedness and rounding mode,
//  valid/ready handshakes on both sides. Sits in the FPU beside the add/mul/div units, feeding FCVT.S.W/WU.
// PARAMETERS
//  INT_W  32  integer input width; must satisfy INT_W-1 < 2**(EXP_W-1)-1, so no overflow/Inf is possible
//  EXP_W  8   exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W  23  stored mantissa width (hidden bit excluded)
// PORTS
//  clk        in   1              clock
//  rst        in   1              reset, synchronous, active-low
//  in_valid   in   1              operand valid
//  in_ready   out  1              converter can accept an operand
//  in_a       in   INT_W          integer operand
//  in_signed  in   1              1: in_a is two's complement; 0: unsigned
//  in_rm      in   3              rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 are treated as RNE
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts the result
//  out_z      out  1+EXP_W+MAN_W  {sign, biased exponent, mantissa}
//  out_nx     out  1              inexact flag (only when I2F_FLAGS_EN is defined)
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): state<=IDLE; out_valid=0, out_z=0, out_nx=0. in_ready=0 while rst=0.
//    Reset mid-operation discards the in-flight operand. No output is produced for it.
//  - States: IDLE -> NORM -> ROUND -> PACK -> OUT -> IDLE.
//    Zero operand: IDLE -> PACK -> OUT.
//  - IDLE: in_ready=1 (in_ready is 1 only in IDLE). On in_valid&in_ready, latch the following and go to NORM:
//    sign = in_signed & in_a[INT_W-1]; mag = sign ? -in_a : in_a (INT_W-bit unsigned); exp = INT_W-1; rm.
//    The most-negative input gives mag = 2**(INT_W-1), which is correct as unsigned.
//    If in_a==0: sign=0, result +0, go to PACK.
//  - NORM: one bit per cycle. If mag[INT_W-1]==0: mag<<=1, exp-=1, stay in NORM. Otherwise go to ROUND.
//  - ROUND: frac = mag[INT_W-2:0], left-aligned to MAN_W and zero-padded if INT_W-1 < MAN_W.
//    g = first bit below the mantissa LSB; s = OR of all lower bits; inexact = g|s.
//    Increment condition per mode:
//      RNE: g&(s|lsb)   RTZ: never   RDN: inexact&sign   RUP: inexact&~sign   RMM: g
//    Mantissa carry-out (all ones + 1): mantissa<=0, exp+=1.
//    If INT_W-1 <= MAN_W the result is always exact.
//  - PACK: out_z <= {sign, exp+bias, mantissa}. Zero case: out_z <= all zeros.
//  - OUT: out_valid=1. out_z and out_nx are held stable until out_ready. On out_valid&out_ready: out_valid<=0, go to IDLE.
//  - Latency from accept edge to out_valid: lz+3 cycles, where lz = leading zeros of mag. Zero operand: 1 cycle.
//    Minimum accept-to-accept interval is latency+2 cycles, with out_ready tied high.
//  - in_a, in_signed and in_rm are don't-care when not accepted. Inputs are sampled only at the accept edge.
// CONFIGURATION
//  - I2F_FLAGS_EN defined: port out_nx exists. out_nx = inexact, registered in PACK and valid with out_valid.
//    Reset value 0. It is 0 for zero or exact inputs.
//  - I2F_FLAGS_EN undefined: port out_nx and its logic are absent. out_z is identical in both builds.
// TESTING (defaults: INT_W=32, EXP_W=8, MAN_W=23)
//  - in_a=1, unsigned, RNE -> out_z=0x3F800000, out_valid 34 cycles after accept (lz=31); in_a=0 -> 0x00000000 after 1 cycle.
//  - Signed: in_a=0xFFFFFFFF -> 0xBF800000; in_a=0x80000000 -> 0xCF000000, nx=0.
//    Unsigned: in_a=0x80000000 -> 0x4F000000.
//  - Unsigned 0xFFFFFFFF: RNE -> 0x4F800000 (carry into exponent), RTZ/RDN -> 0x4F7FFFFF, nx=1.
//  - in_a=0x01000001 unsigned: RNE -> 0x4B800000 (tie to even), RUP -> 0x4B800001, RMM -> 0x4B800001, RTZ -> 0x4B800000.
//    Signed, in_a=-0x01000001: RDN -> 0xCB800001.
//  - Backpressure: hold out_ready=0 for 10 cycles -> out_z stable, in_ready=0, a held in_valid is not accepted;
//    release -> one transfer, then next accept.
//  - Pull rst low during NORM -> out_valid stays 0, in_ready returns to 1 the cycle after release, next result correct.

Source files
------------

// File: rtl/int_to_float_param.sv
// rtl/int_to_float_param.sv - multi-cycle signed/unsigned integer to float converter
// Optional inexact flag output out_nx is built when I2F_FLAGS_EN is defined.
module int_to_float_param #(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_a,
  input  logic                   in_signed,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z
`ifdef I2F_FLAGS_EN
  ,
  output logic                   out_nx
`endif
);

  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int FRAC_W = INT_W - 1;
  // Extended fraction always has room for the mantissa plus guard and sticky bits.
  localparam int EXT_W  = ((FRAC_W > MAN_W) ? FRAC_W : MAN_W) + 2;
  localparam int PAD_W  = EXT_W - FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_OUT
  } state_t;

  state_t state;
  state_t next_state;

  logic             sign_r;
  logic             zero_r;
  logic [INT_W-1:0] mag_r;
  logic [EXP_W-1:0] exp_r;
  logic [MAN_W-1:0] man_r;
  logic [2:0]       rm_r;
`ifdef I2F_FLAGS_EN
  logic             nx_r;
`endif

  logic             accept;
  logic             in_neg;
  logic [EXT_W-1:0] ext;
  logic [MAN_W-1:0] man_trunc;
  logic [MAN_W:0]   man_inc;
  logic             g_bit;
  logic             s_bit;
  logic             inexact;
  logic             inc;

  assign accept = in_valid & in_ready;
  assign in_neg = in_signed & in_a[INT_W-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = (in_a == '0) ? S_PACK : S_NORM;
      S_NORM:  if (mag_r[INT_W-1]) next_state = S_ROUND;
      S_ROUND: next_state = S_PACK;
      S_PACK:  next_state = S_OUT;
      S_OUT:   if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state == S_IDLE);
    out_valid = (state == S_OUT);
  end

  // Hidden bit dropped; fraction left-aligned so the mantissa is its top MAN_W bits.
  always_comb begin
    ext       = {mag_r[INT_W-2:0], {PAD_W{1'b0}}};
    man_trunc = ext[EXT_W-1 -: MAN_W];
    g_bit     = ext[EXT_W-1-MAN_W];
    s_bit     = |ext[EXT_W-2-MAN_W:0];
    inexact   = g_bit | s_bit;
    man_inc   = {1'b0, man_trunc} + (MAN_W+1)'(1);
  end

  always_comb begin
    case (rm_r)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact & sign_r;
      3'd3:    inc = inexact & ~sign_r;
      3'd4:    inc = g_bit;
      default: inc = g_bit & (s_bit | man_trunc[0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      mag_r  <= '0;
      exp_r  <= '0;
      man_r  <= '0;
      rm_r   <= '0;
      out_z  <= '0;
`ifdef I2F_FLAGS_EN
      nx_r   <= 1'b0;
      out_nx <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign_r <= in_neg;
            mag_r  <= in_neg ? -in_a : in_a;
            exp_r  <= EXP_W'(INT_W - 1);
            rm_r   <= in_rm;
            zero_r <= (in_a == '0);
          end
        end
        S_NORM: begin
          if (!mag_r[INT_W-1]) begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        S_ROUND: begin
          man_r <= inc ? man_inc[MAN_W-1:0] : man_trunc;
          // All-ones mantissa rounding up becomes 1.0 at the next binade.
          if (inc && man_inc[MAN_W]) exp_r <= exp_r + EXP_W'(1);
`ifdef I2F_FLAGS_EN
          nx_r <= inexact;
`endif
        end
        S_PACK: begin
          out_z <= zero_r ? '0 : {sign_r, exp_r + EXP_W'(BIAS), man_r};
`ifdef I2F_FLAGS_EN
          out_nx <= ~zero_r & nx_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_param.sv
// tb/tb_int_to_float_param.sv - directed self-checking bench for int_to_float_param
// Checks out_nx only when I2F_FLAGS_EN is defined.
module tb_int_to_float_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        in_signed;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
`ifdef I2F_FLAGS_EN
  logic        out_nx;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int_to_float_param #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_signed (in_signed),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z)
`ifdef I2F_FLAGS_EN
    ,
    .out_nx    (out_nx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic check_nx(input string tag, input logic exp_nx);
`ifdef I2F_FLAGS_EN
    check(tag, "nx", {31'd0, out_nx}, {31'd0, exp_nx});
`else
    if (exp_nx === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  // Counts edges after the accept edge until out_valid; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic sg, input logic [2:0] rm,
                        input logic [31:0] exp_z, input logic exp_nx, input int exp_lat);
    int lat;
    @(negedge clk);
    check(tag, "rdy", {31'd0, in_ready}, 32'd1);
    in_a = a; in_signed = sg; in_rm = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_signed = 1'($urandom); in_rm = 3'($urandom);
    wait_valid(lat);
    check(tag, "lat", 32'(lat), 32'(exp_lat));
    check(tag, "z", out_z, exp_z);
    check_nx(tag, exp_nx);
    @(posedge clk); #1;
    check(tag, "vld_clr", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_signed = 1'b0; in_rm = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", "rdy", {31'd0, in_ready}, 32'd0);
    check("reset", "vld", {31'd0, out_valid}, 32'd0);
    check("reset", "z", out_z, 32'd0);
    check_nx("reset", 1'b0);
    @(negedge clk) rst = 1'b1;

    run_op("u_one",      32'h00000001, 1'b0, 3'd0, 32'h3F800000, 1'b0, 34);
    run_op("zero",       32'h00000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1);
    run_op("s_m1",       32'hFFFFFFFF, 1'b1, 3'd0, 32'hBF800000, 1'b0, 34);
    run_op("s_min",      32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0, 3);
    run_op("u_msb",      32'h80000000, 1'b0, 3'd0, 32'h4F000000, 1'b0, 3);
    run_op("u_max_rne",  32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1, 3);
    run_op("u_max_rtz",  32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1, 3);
    run_op("u_max_rdn",  32'hFFFFFFFF, 1'b0, 3'd2, 32'h4F7FFFFF, 1'b1, 3);
    run_op("tie_rne",    32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1, 10);
    run_op("tie_rup",    32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1, 10);
    run_op("tie_rmm",    32'h01000001, 1'b0, 3'd4, 32'h4B800001, 1'b1, 10);
    run_op("tie_rtz",    32'h01000001, 1'b0, 3'd1, 32'h4B800000, 1'b1, 10);
    run_op("tie_rm7",    32'h01000001, 1'b0, 3'd7, 32'h4B800000, 1'b1, 10);
    run_op("tie_odd",    32'h01000003, 1'b0, 3'd0, 32'h4B800002, 1'b1, 10);
    run_op("s_tie_rdn",  32'hFEFFFFFF, 1'b1, 3'd2, 32'hCB800001, 1'b1, 10);
    run_op("s_three",    32'h00000003, 1'b1, 3'd0, 32'h40400000, 1'b0, 33);

    // Backpressure: result held while a second operand waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 32'h80000000; in_signed = 1'b0; in_rm = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h00000005;
    wait_valid(lat);
    check("bp", "lat", 32'(lat), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", "vld", {31'd0, out_valid}, 32'd1);
      check("bp_hold", "z", out_z, 32'h4F000000);
      check("bp_hold", "rdy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel", "vld", {31'd0, out_valid}, 32'd0);
    check("bp_rel", "rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next", "rdy", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check("bp_next", "lat", 32'(lat), 32'd32);
    check("bp_next", "z", out_z, 32'h40A00000);
    @(posedge clk); #1;
    check("bp_next", "vld_clr", {31'd0, out_valid}, 32'd0);

    // Reset during normalisation drops the operand.
    @(negedge clk);
    in_a = 32'h00000001; in_signed = 1'b0; in_rm = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid", "vld", {31'd0, out_valid}, 32'd0);
    check("rst_mid", "rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rel", "rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_rel", "no_out", 32'(seen), 32'd0);
    run_op("after_rst",  32'h00000003, 1'b1, 3'd0, 32'h40400000, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
